video_tpg: RTL
==============

// Module: video_tpg
// PURPOSE
//  Video source for the filter chain: generates raster timing (de/hs/vs) and a selectable RGB test pattern.
//  Output bus matches the inputs of the pixel filters (di_i/de_i/hs_i/vs_i), packed {b,g,r}.
//  Used as stimulus in filter benches and as on-board bring-up source ahead of the filter pipeline.
// PARAMETERS
//  PIXEL_WIDTH  8    bits per colour component
//  H_ACTIVE     640  active pixels per line
//  H_FP         16   horizontal front porch (clk)
//  H_SYNC       96   hsync width (clk)
//  H_BP         48   horizontal back porch (clk)
//  V_ACTIVE     480  active lines per frame
//  V_FP         10   vertical front porch (lines)
//  V_SYNC       2    vsync width (lines)
//  V_BP         33   vertical back porch (lines)
// PORTS
//  clk           in   1              pixel clock
//  rst_n         in   1              asynchronous reset, active-low
//  en_i          in   1              run request; start and stop honoured only at frame boundary
//  pattern_i     in   2              0 solid, 1 colour bars, 2 horizontal ramp, 3 checkerboard
//  color_i       in   3*PIXEL_WIDTH  solid colour {b,g,r} for pattern 0
//  do_o          out  3*PIXEL_WIDTH  pixel {b,g,r}; zero when de_o=0
//  de_o / hs_o / vs_o  out  1 each   data enable / hsync / vsync, active-high
//  busy_o        out  1              1 while in RUN state
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, state IDLE. Reset mid-frame aborts immediately; no partial flush.
//  - FSM: IDLE -> RUN when en_i=1 (frame begins next clk at h=0,v=0). RUN -> IDLE when en_i=0 at
//    last clk of frame (h=H_TOTAL-1, v=V_TOTAL-1); deassert mid-frame completes the frame.
//  - Counters h in [0,H_TOTAL-1], v in [0,V_TOTAL-1]; H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, same for V.
//    h wraps to 0 and v increments; v wraps to 0 at end of frame. Widths via $clog2(total).
//  - Raster order per line/frame: active, front porch, sync, back porch.
//    de = h<H_ACTIVE && v<V_ACTIVE; hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs likewise on v (whole lines).
//  - All outputs registered; outputs lag counters by exactly 1 clk; de/hs/vs/do_o mutually aligned.
//  - pattern_i and color_i latched at frame start (h=0,v=0); changes mid-frame take effect next frame.
//  - Patterns (x=h, y=v, M=2^PIXEL_WIDTH-1):
//    0: color_i.  1: 8 bars, bar = x*8/H_ACTIVE, colours white,yellow,cyan,green,magenta,red,blue,black
//    (component M or 0).  2: r=g=b = x[PIXEL_WIDTH-1:0] (wraps).  3: 8x8 cells, x[3]^y[3] ? all M : 0.
//  - In IDLE: de/hs/vs/do_o held 0, busy_o=0.
// CONFIGURATION
//  - Macro VIDEO_TPG_MOTION_EN: adds 16-bit frame counter (reset 0, increments at each frame end, wraps);
//    patterns 2 and 3 use x' = x + frame_cnt so image scrolls 1 px/frame. Without it patterns are static
//    and no frame counter exists. Port list unchanged in both builds.
// STRUCTURE
//  - Package video_tpg_pkg: pattern enum (TPG_SOLID, TPG_BARS, TPG_RAMP, TPG_CHECK), FSM state enum,
//    8-entry bar colour table as 3-bit {b,g,r} on/off constants.
//  - Sub-module video_timing_gen: h/v counters, de/hs/vs and frame-start/frame-end strobes;
//    top adds FSM, pattern latch and pixel generation with matching 1-clk register.
// TESTING (H_ACTIVE=16,H_FP=2,H_SYNC=3,H_BP=3 -> 24; V_ACTIVE=4,V_FP=1,V_SYNC=2,V_BP=1 -> 8; frame 192 clk)
//  - Reset then en_i=1: first de_o one clk after RUN entry; 16 de clk per line, 4 active lines, 64 de per frame;
//    hs_o high for 3 clk starting 18 clk after de rise; vs_o high 48 clk starting at line 5.
//  - pattern_i=0, color_i=24'h102030: every de pixel = 24'h102030; every non-de pixel = 0.
//  - pattern_i=1: pixels 0-1 = 24'hFFFFFF, 2-3 = 24'h00FFFF (yellow), 14-15 = 0.
//  - pattern_i switched 2->3 mid-frame: remainder of frame stays ramp (pixel x = x*0x010101); next frame checkerboard.
//  - en_i dropped at line 2: frame completes (192 clk total), then IDLE, busy_o=0, outputs 0; rst_n low
//    mid-line: all outputs 0 same clk asynchronously, restart begins at h=0,v=0.
//  - VIDEO_TPG_MOTION_EN: ramp frame n pixel 0 = n*0x010101; without macro identical every frame.

Source files
------------

// File: rtl/video_tpg_pkg.sv
// video_tpg_pkg: shared types and constants for the video test-pattern generator.
// Pattern and FSM state enums plus the colour-bar table as 3-bit {b,g,r} on/off
// flags (each flag expands to a full-scale or zero component).
package video_tpg_pkg;

    typedef enum logic [1:0] {
        TPG_SOLID = 2'd0,
        TPG_BARS  = 2'd1,
        TPG_RAMP  = 2'd2,
        TPG_CHECK = 2'd3
    } tpg_pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tpg_state_e;

    // Entry i is bar i from the left; bit 2 = blue, bit 1 = green, bit 0 = red.
    // Order: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000,  // 7 black
        3'b100,  // 6 blue
        3'b001,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b110,  // 2 cyan
        3'b011,  // 1 yellow
        3'b111   // 0 white
    };

endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running h/v raster counters while run_i is high.
// Produces unregistered de/hs/vs decoded from the counters plus strobes for the
// first (h=0,v=0) and last (h=H_TOTAL-1,v=V_TOTAL-1) clock of the frame.
// Raster order per line/frame: active, front porch, sync, back porch.
module video_timing_gen #(
    parameter  int H_ACTIVE = 640,
    parameter  int H_FP     = 16,
    parameter  int H_SYNC   = 96,
    parameter  int H_BP     = 48,
    parameter  int V_ACTIVE = 480,
    parameter  int V_FP     = 10,
    parameter  int V_SYNC   = 2,
    parameter  int V_BP     = 33,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run_i,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          de_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          frame_start_o,
    output logic          frame_end_o
);

    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_q == HW'(H_TOTAL - 1));
    assign v_last = (v_q == VW'(V_TOTAL - 1));

    // Advance the raster one pixel per clock while running; wrap h then v.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (run_i) begin
            if (h_last) begin
                h_q <= '0;
                v_q <= v_last ? '0 : v_q + VW'(1);
            end else begin
                h_q <= h_q + HW'(1);
            end
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign de_o          = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    assign hs_o          = (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_o          = (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);
    assign frame_start_o = (h_q == '0) && (v_q == '0);
    assign frame_end_o   = h_last && v_last;

endmodule

// File: rtl/video_tpg.sv
// video_tpg: raster timing plus selectable RGB test pattern, output {b,g,r}.
// Start/stop requests on en_i only take effect at frame boundaries; pattern and
// colour are captured on the first clock of each frame. Every output is
// registered one clock behind the raster counters.
// Optional build macro VIDEO_TPG_MOTION_EN: adds a 16-bit frame counter that
// offsets x for the ramp and checkerboard patterns (scroll 1 px per frame).
module video_tpg
    import video_tpg_pkg::*;
#(
    parameter  int PIXEL_WIDTH = 8,
    parameter  int H_ACTIVE    = 640,
    parameter  int H_FP        = 16,
    parameter  int H_SYNC      = 96,
    parameter  int H_BP        = 48,
    parameter  int V_ACTIVE    = 480,
    parameter  int V_FP        = 10,
    parameter  int V_SYNC      = 2,
    parameter  int V_BP        = 33,
    localparam int DW          = 3 * PIXEL_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [1:0]    pattern_i,
    input  logic [DW-1:0] color_i,
    output logic [DW-1:0] do_o,
    output logic          de_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          busy_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // x position needs the ramp bits and bit 3 for the checkerboard cells.
    localparam int XW      = (PIXEL_WIDTH > 4) ? PIXEL_WIDTH : 4;

    tpg_state_e    state_q;
    logic          busy_q;
    logic          run;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          de_t;
    logic          hs_t;
    logic          vs_t;
    logic          frame_start;
    logic          frame_end;

    tpg_pattern_e  pattern_q;
    logic [DW-1:0] color_q;
    tpg_pattern_e  pat_sel;
    logic [DW-1:0] color_sel;

    logic [XW-1:0] x_pos;
    logic          y_cell;
    logic [2:0]    bar_rgb;
    logic [DW-1:0] pix_d;

    logic [DW-1:0] do_q;
    logic          de_q;
    logic          hs_q;
    logic          vs_q;

    assign run = (state_q == ST_RUN);

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (run),
        .h_o           (h_cnt),
        .v_o           (v_cnt),
        .de_o          (de_t),
        .hs_o          (hs_t),
        .vs_o          (vs_t),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end)
    );

    // Run/idle control: start on request from idle, stop only on the last clock of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (frame_end && !en_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Capture pattern and colour on the first clock of each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= TPG_SOLID;
            color_q   <= '0;
        end else if (run && frame_start) begin
            pattern_q <= tpg_pattern_e'(pattern_i);
            color_q   <= color_i;
        end
    end

    // The first pixel of a frame must already use the new selection, so bypass the latch there.
    assign pat_sel   = frame_start ? tpg_pattern_e'(pattern_i) : pattern_q;
    assign color_sel = frame_start ? color_i : color_q;

`ifdef VIDEO_TPG_MOTION_EN
    logic [15:0] frame_cnt_q;

    // Frame counter drives the scroll offset; it steps on every completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (run && frame_end) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign x_pos = XW'(h_cnt) + XW'(frame_cnt_q);
`else
    assign x_pos = XW'(h_cnt);
`endif

    assign y_cell  = ((int'(v_cnt) >> 3) & 1) == 1;
    assign bar_rgb = BAR_TABLE[3'((int'(h_cnt) * 8) / H_ACTIVE)];

    // Pixel for the current raster position; blanked outside the active area.
    always_comb begin
        pix_d = '0;
        case (pat_sel)
            TPG_SOLID: pix_d = color_sel;
            TPG_BARS:  pix_d = {{PIXEL_WIDTH{bar_rgb[2]}},
                                {PIXEL_WIDTH{bar_rgb[1]}},
                                {PIXEL_WIDTH{bar_rgb[0]}}};
            TPG_RAMP:  pix_d = {3{x_pos[PIXEL_WIDTH-1:0]}};
            TPG_CHECK: pix_d = {DW{x_pos[3] ^ y_cell}};
            default:   pix_d = '0;
        endcase
        if (!de_t) begin
            pix_d = '0;
        end
    end

    // Output register: one clock behind the counters, all zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_q <= '0;
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else if (run) begin
            do_q <= pix_d;
            de_q <= de_t;
            hs_q <= hs_t;
            vs_q <= vs_t;
        end else begin
            do_q <= '0;
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end
    end

    assign do_o   = do_q;
    assign de_o   = de_q;
    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign busy_o = busy_q;

endmodule
